manchester_decoder: RTL

- Receive-side counterpart of the team's Manchester encoder.
- Takes the half-bit line stream y, qualified by dv, and pairs consecutive half-bits into symbols.
- Decodes each symbol back to a data bit and flags code violations.
- Aligns to the symbol boundary by slipping one half-bit on a violation; delivers bits only once locked.
- Sits between the line sampler and the downstream bit consumer.

---
 rtl/manchester_decoder.sv | 92 +++++++++
 1 files changed

// File: rtl/manchester_decoder.sv
// manchester_decoder: pairs qualified half-bits into Manchester symbols, aligns by slipping on violations, delivers bits once locked
module manchester_decoder #(
    parameter int LOCK_SYMS = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dv,
    input  logic             y,
    output logic             q,
    output logic             q_valid,
    output logic             locked,
    output logic             code_err,
    output logic [CNT_W-1:0] sym_cnt
);
    localparam logic [0:0] H1       = 1'b0;
    localparam logic [0:0] H2       = 1'b1;
    localparam logic [3:0] LOCK_MAX = 4'(LOCK_SYMS);
    localparam logic [3:0] LOCK_M1  = 4'(LOCK_SYMS - 1);

    logic [0:0]       state_q, state_d;
    logic             h_q, h_d;
    logic [3:0]       good_q, good_d;
    logic             q_q, q_d;
    logic             qv_q, qv_d;
    logic             lock_q, lock_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // next-state: capture first half, then judge the pair; a violation keeps the current half as a new first half
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        good_d  = good_q;
        q_d     = q_q;
        qv_d    = 1'b0;
        lock_d  = lock_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        if (dv) begin
            if (state_q == H1) begin
                h_d     = y;
                state_d = H2;
            end else if (y != h_q) begin
                state_d = H1;
                if (lock_q || good_q == LOCK_M1) begin
                    q_d    = y;
                    qv_d   = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    lock_d = 1'b1;
                    good_d = LOCK_MAX;
                end else begin
                    good_d = good_q + 4'd1;
                end
            end else begin
                err_d  = 1'b1;
                lock_d = 1'b0;
                good_d = 4'd0;
                h_d    = y;
            end
        end
    end

    // state and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= H1;
            h_q     <= 1'b0;
            good_q  <= 4'd0;
            q_q     <= 1'b0;
            qv_q    <= 1'b0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            good_q  <= good_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q        = q_q;
    assign q_valid  = qv_q;
    assign locked   = lock_q;
    assign code_err = err_q;
    assign sym_cnt  = cnt_q;
endmodule
